// File: rtl/fx_writeback_queue.sv
// fx_writeback_queue
//   In-order writeback buffer between the fixed-point execution units and the
//   FX register file. Accepts up to two results per cycle (A before B), and
//   each cycle drains the longest in-order run of up to four queued entries
//   that has no repeated GPR address and at most one XER update. The drained
//   entries drive the four GPR write ports and the XER write port from
//   registers.
//
// Ports
//   clock_i, reset_i (async, active-low), flush_i (sync, discards queue)
//   resA*/resB*      : two result inputs (valid, GPR addr/value, XER enable/value)
//   inReady_o        : room for two results this cycle
//   gprWriteN*_o     : GPR write ports 1..4 (port 1 carries the oldest entry)
//   XERWriteEn_o/XERVal_o : XER write port
//   count_o          : current queue occupancy
module fx_writeback_queue #(
  parameter int regSize           = 64,
  parameter int numGPRAddressBits = 6,
  parameter int queueDepth        = 8,
  parameter int fxWbInstance      = 0
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          flush_i,
  input  logic                          resAValid_i,
  input  logic [numGPRAddressBits-1:0]  resAAddr_i,
  input  logic [regSize-1:0]            resAVal_i,
  input  logic                          resAXerEn_i,
  input  logic [regSize-1:0]            resAXerVal_i,
  input  logic                          resBValid_i,
  input  logic [numGPRAddressBits-1:0]  resBAddr_i,
  input  logic [regSize-1:0]            resBVal_i,
  input  logic                          resBXerEn_i,
  input  logic [regSize-1:0]            resBXerVal_i,
  output logic                          inReady_o,
  output logic                          gprWrite1En_o,
  output logic                          gprWrite2En_o,
  output logic                          gprWrite3En_o,
  output logic                          gprWrite4En_o,
  output logic [numGPRAddressBits-1:0]  gprWriteAddr1_o,
  output logic [numGPRAddressBits-1:0]  gprWriteAddr2_o,
  output logic [numGPRAddressBits-1:0]  gprWriteAddr3_o,
  output logic [numGPRAddressBits-1:0]  gprWriteAddr4_o,
  output logic [regSize-1:0]            gprWrite1Val_o,
  output logic [regSize-1:0]            gprWrite2Val_o,
  output logic [regSize-1:0]            gprWrite3Val_o,
  output logic [regSize-1:0]            gprWrite4Val_o,
  output logic                          XERWriteEn_o,
  output logic [regSize-1:0]            XERVal_o,
  output logic [$clog2(queueDepth):0]   count_o
);
  localparam int ptrW     = $clog2(queueDepth);
  localparam int cntW     = ptrW + 1;
  localparam int numPorts = 4;

  logic [numGPRAddressBits-1:0] entryAddr   [queueDepth];
  logic [regSize-1:0]           entryVal    [queueDepth];
  logic                         entryXerEn  [queueDepth];
  logic [regSize-1:0]           entryXerVal [queueDepth];

  logic [ptrW-1:0] head;
  logic [ptrW-1:0] tail;
  logic [cntW-1:0] count;
  logic            inReady;
  logic            enqA;
  logic            enqB;
  logic [1:0]      enqNum;
  logic [ptrW-1:0] tailB;

  // Ready looks only at registered occupancy; same-cycle drains are not credited.
  assign inReady = (count <= cntW'(queueDepth - 2));
  assign enqA    = inReady & resAValid_i;
  assign enqB    = inReady & resBValid_i;
  assign enqNum  = {1'b0, enqA} + {1'b0, enqB};
  // B lands right behind A when both are accepted, otherwise at tail.
  assign tailB   = tail + ptrW'(enqA);

  // Entry storage carries no reset; occupancy is tracked by head/count alone.
  always_ff @(posedge clock_i) begin
    if (!flush_i) begin
      if (enqA) begin
        entryAddr[tail]   <= resAAddr_i;
        entryVal[tail]    <= resAVal_i;
        entryXerEn[tail]  <= resAXerEn_i;
        entryXerVal[tail] <= resAXerVal_i;
      end
      if (enqB) begin
        entryAddr[tailB]   <= resBAddr_i;
        entryVal[tailB]    <= resBVal_i;
        entryXerEn[tailB]  <= resBXerEn_i;
        entryXerVal[tailB] <= resBXerVal_i;
      end
    end
  end

  // ---- stage p0: drain selection from the queue head ----
  logic [ptrW-1:0]     drainIdx [numPorts];
  logic [numPorts-1:0] drainSel;
  logic [2:0]          drainNum;
  logic                drainXer;
  logic [regSize-1:0]  drainXerVal;
  logic                drainStop;

  always_comb begin
    drainSel    = '0;
    drainNum    = '0;
    drainXer    = 1'b0;
    drainXerVal = '0;
    drainStop   = 1'b0;
    for (int k = 0; k < numPorts; k++) begin
      drainIdx[k] = head + ptrW'(k);
    end
    // Selection is a contiguous prefix: once stopped, nothing later is taken,
    // so every earlier slot is known to be selected when comparing addresses.
    for (int k = 0; k < numPorts; k++) begin
      if (cntW'(k) >= count) drainStop = 1'b1;
      if (entryXerEn[drainIdx[k]] && drainXer) drainStop = 1'b1;
      for (int j = 0; j < k; j++) begin
        if (entryAddr[drainIdx[j]] == entryAddr[drainIdx[k]]) drainStop = 1'b1;
      end
      if (!drainStop) begin
        drainSel[k] = 1'b1;
        drainNum    = drainNum + 3'd1;
        if (entryXerEn[drainIdx[k]]) begin
          drainXer    = 1'b1;
          drainXerVal = entryXerVal[drainIdx[k]];
        end
      end
    end
  end

  // ---- stage p1: registered write ports, pointers and occupancy ----
  logic [numPorts-1:0]          wrVld_p1;
  logic [numGPRAddressBits-1:0] wrAddr_p1 [numPorts];
  logic [regSize-1:0]           wrVal_p1  [numPorts];
  logic                         xerVld_p1;
  logic [regSize-1:0]           xerVal_p1;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wrVld_p1  <= '0;
      xerVld_p1 <= 1'b0;
      xerVal_p1 <= '0;
      for (int k = 0; k < numPorts; k++) begin
        wrAddr_p1[k] <= '0;
        wrVal_p1[k]  <= '0;
      end
    end else if (flush_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wrVld_p1  <= '0;
      xerVld_p1 <= 1'b0;
    end else begin
      head      <= head + ptrW'(drainNum);
      tail      <= tail + ptrW'(enqNum);
      count     <= count + cntW'(enqNum) - cntW'(drainNum);
      wrVld_p1  <= drainSel;
      xerVld_p1 <= drainXer;
      if (drainXer) xerVal_p1 <= drainXerVal;
      // Idle ports keep their last address/value; only the enable drops.
      for (int k = 0; k < numPorts; k++) begin
        if (drainSel[k]) begin
          wrAddr_p1[k] <= entryAddr[drainIdx[k]];
          wrVal_p1[k]  <= entryVal[drainIdx[k]];
        end
      end
    end
  end

`ifdef DEBUG
  always_ff @(posedge clock_i) begin
    if (reset_i && !inReady && (resAValid_i || resBValid_i))
      $display("fx_writeback_queue[%0d]: result dropped, queue not ready (count=%0d)",
               fxWbInstance, count);
  end
`else
  localparam int unusedInstance = fxWbInstance;
`endif

  assign inReady_o       = inReady;
  assign count_o         = count;
  assign gprWrite1En_o   = wrVld_p1[0];
  assign gprWrite2En_o   = wrVld_p1[1];
  assign gprWrite3En_o   = wrVld_p1[2];
  assign gprWrite4En_o   = wrVld_p1[3];
  assign gprWriteAddr1_o = wrAddr_p1[0];
  assign gprWriteAddr2_o = wrAddr_p1[1];
  assign gprWriteAddr3_o = wrAddr_p1[2];
  assign gprWriteAddr4_o = wrAddr_p1[3];
  assign gprWrite1Val_o  = wrVal_p1[0];
  assign gprWrite2Val_o  = wrVal_p1[1];
  assign gprWrite3Val_o  = wrVal_p1[2];
  assign gprWrite4Val_o  = wrVal_p1[3];
  assign XERWriteEn_o    = xerVld_p1;
  assign XERVal_o        = xerVal_p1;

endmodule

// File: tb/tb_fx_writeback_queue.sv
// Bench for fx_writeback_queue: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_fx_writeback_queue;
  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        flush = 1'b0;
  logic        aV, aX, bV, bX;
  logic [5:0]  aAddr, bAddr;
  logic [63:0] aVal, aXV, bVal, bXV;

  logic        inReady;
  logic        en1, en2, en3, en4;
  logic [5:0]  ad1, ad2, ad3, ad4;
  logic [63:0] v1, v2, v3, v4;
  logic        xerEn;
  logic [63:0] xerVal;
  logic [3:0]  count;

  fx_writeback_queue dut (
    .clock_i(clk), .reset_i(rstN), .flush_i(flush),
    .resAValid_i(aV), .resAAddr_i(aAddr), .resAVal_i(aVal),
    .resAXerEn_i(aX), .resAXerVal_i(aXV),
    .resBValid_i(bV), .resBAddr_i(bAddr), .resBVal_i(bVal),
    .resBXerEn_i(bX), .resBXerVal_i(bXV),
    .inReady_o(inReady),
    .gprWrite1En_o(en1), .gprWrite2En_o(en2), .gprWrite3En_o(en3), .gprWrite4En_o(en4),
    .gprWriteAddr1_o(ad1), .gprWriteAddr2_o(ad2), .gprWriteAddr3_o(ad3), .gprWriteAddr4_o(ad4),
    .gprWrite1Val_o(v1), .gprWrite2Val_o(v2), .gprWrite3Val_o(v3), .gprWrite4Val_o(v4),
    .XERWriteEn_o(xerEn), .XERVal_o(xerVal), .count_o(count)
  );

  always #5 clk = ~clk;

  logic [3:0]  dutEn;
  logic [5:0]  dutAddr [4];
  logic [63:0] dutVal  [4];
  assign dutEn = {en4, en3, en2, en1};
  assign dutAddr[0] = ad1; assign dutAddr[1] = ad2; assign dutAddr[2] = ad3; assign dutAddr[3] = ad4;
  assign dutVal[0] = v1;   assign dutVal[1] = v2;   assign dutVal[2] = v3;   assign dutVal[3] = v4;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] val;
    logic        xer;
    logic [63:0] xv;
  } entT;

  entT         q[$];
  logic        expEn   [4];
  logic [5:0]  expAddr [4];
  logic [63:0] expVal  [4];
  logic        expXerEn;
  logic [63:0] expXerVal;
  logic [63:0] rf [64];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    for (int k = 0; k < 4; k++) begin
      expEn[k] = 1'b0; expAddr[k] = '0; expVal[k] = '0;
    end
    expXerEn  = 1'b0;
    expXerVal = '0;
  endtask

  // A prefix of length n may drain together if its addresses are all
  // distinct and it holds at most one XER update.
  function automatic bit prefixOk(int n);
    int xers = 0;
    for (int i = 0; i < n; i++) begin
      if (q[i].xer) xers++;
      for (int j = i + 1; j < n; j++)
        if (q[i].addr == q[j].addr) return 1'b0;
    end
    return (xers <= 1);
  endfunction

  task automatic idle();
    flush = 1'b0;
    aV = 1'b0; aAddr = '0; aVal = '0; aX = 1'b0; aXV = '0;
    bV = 1'b0; bAddr = '0; bVal = '0; bX = 1'b0; bXV = '0;
  endtask

  task automatic setA(input bit v, input int addr, input logic [63:0] val,
                      input bit x = 1'b0, input logic [63:0] xv = 64'd0);
    aV = v; aAddr = 6'(addr); aVal = val; aX = x; aXV = xv;
  endtask

  task automatic setB(input bit v, input int addr, input logic [63:0] val,
                      input bit x = 1'b0, input logic [63:0] xv = 64'd0);
    bV = v; bAddr = 6'(addr); bVal = val; bX = x; bXV = xv;
  endtask

  // One clock: predict from the pre-edge model state, clock, then compare.
  task automatic cycle();
    bit ready;
    int n;
    entT e;
    ready = (q.size() <= QD - 2);
    chk("inReady", inReady, ready);
    if (flush) begin
      q.delete();
      for (int k = 0; k < 4; k++) expEn[k] = 1'b0;
      expXerEn = 1'b0;
    end else begin
      n = (q.size() < 4) ? q.size() : 4;
      while (n > 0 && !prefixOk(n)) n--;
      expXerEn = 1'b0;
      for (int k = 0; k < 4; k++) begin
        expEn[k] = (k < n);
        if (k < n) begin
          expAddr[k] = q[k].addr;
          expVal[k]  = q[k].val;
          if (q[k].xer) begin
            expXerEn  = 1'b1;
            expXerVal = q[k].xv;
          end
        end
      end
      repeat (n) void'(q.pop_front());
      if (ready && aV) begin
        e.addr = aAddr; e.val = aVal; e.xer = aX; e.xv = aXV; q.push_back(e);
      end
      if (ready && bV) begin
        e.addr = bAddr; e.val = bVal; e.xer = bX; e.xv = bXV; q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("count", count, q.size());
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("en%0d", k + 1), dutEn[k], expEn[k]);
      chk($sformatf("addr%0d", k + 1), dutAddr[k], expAddr[k]);
      chk($sformatf("val%0d", k + 1), dutVal[k], expVal[k]);
    end
    chk("xerEn", xerEn, expXerEn);
    chk("xerVal", xerVal, expXerVal);
    for (int k = 0; k < 4; k++)
      if (dutEn[k]) rf[dutAddr[k]] = dutVal[k];
  endtask

  task automatic resetMid();
    #2 rstN = 1'b0;
    #1;
    chk("rst en", dutEn, 4'b0000);
    chk("rst xerEn", xerEn, 1'b0);
    chk("rst count", count, 0);
    chk("rst addr1", ad1, 0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 64; i++) rf[i] = '0;
    idle();
    modelReset();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset en", dutEn, 4'b0000);
    chk("reset count", count, 0);
    chk("reset xerEn", xerEn, 1'b0);
    chk("reset xerVal", xerVal, 0);
    rstN = 1'b1;
    cycle();
    chk("idle inReady", inReady, 1'b1);

    // Two pairs, back to back
    setA(1, 0, 10); setB(1, 1, 11); cycle();
    setA(1, 2, 12); setB(1, 3, 13); cycle();
    chk("pair1 addr1", ad1, 0);  chk("pair1 val1", v1, 10);
    chk("pair1 addr2", ad2, 1);  chk("pair1 val2", v2, 11);
    idle(); cycle();
    chk("pair2 addr1", ad1, 2);  chk("pair2 val1", v1, 12);
    chk("pair2 addr2", ad2, 3);  chk("pair2 val2", v2, 13);
    chk("pair2 count", count, 0);

    // Same-address hazard
    setA(1, 5, 20); setB(1, 5, 21); cycle();
    setA(1, 6, 22); setB(0, 0, 0); cycle();
    chk("haz1 en1", en1, 1'b1); chk("haz1 val1", v1, 20); chk("haz1 en2", en2, 1'b0);
    idle(); cycle();
    chk("haz2 addr1", ad1, 5); chk("haz2 val1", v1, 21);
    chk("haz2 addr2", ad2, 6); chk("haz2 val2", v2, 22);
    cycle();
    chk("haz rf r5", rf[5], 21);

    // XER limit
    setA(1, 7, 30, 1, 64'hA5FF00C3C300FFA5); setB(1, 8, 31, 1, 64'h1); cycle();
    idle(); cycle();
    chk("xer1 en", xerEn, 1'b1); chk("xer1 val", xerVal, 64'hA5FF00C3C300FFA5);
    chk("xer1 en2", en2, 1'b0);
    cycle();
    chk("xer2 en", xerEn, 1'b1); chk("xer2 val", xerVal, 64'h1); chk("xer2 addr1", ad1, 8);
    cycle();

    // Async reset while three entries are queued and draining
    setA(1, 10, 40); setB(1, 10, 41); cycle();
    setA(1, 10, 42); setB(1, 10, 43); cycle();
    chk("pre-rst count", count, 3);
    idle();
    resetMid();
    cycle();

    // Fill with same-address traffic until backpressure
    v = 100;
    for (int i = 0; i < 20 && count != 4'd7; i++) begin
      setA(1, 9, v); setB(1, 9, v + 1); v = v + 2;
      cycle();
    end
    chk("fill count", count, 7);
    chk("fill inReady", inReady, 1'b0);
    setA(1, 9, 999); setB(1, 9, 998);
    cycle();
    chk("fill reready count", count, 6);
    chk("fill reready", inReady, 1'b1);
    idle();
    repeat (8) cycle();

    // Flush with five queued and both inputs valid
    for (int i = 0; i < 20 && count != 4'd5; i++) begin
      setA(1, 9, v); setB(1, 9, v + 1); v = v + 2;
      cycle();
    end
    chk("preflush count", count, 5);
    setA(1, 1, 500); setB(1, 2, 501); flush = 1'b1;
    cycle();
    chk("flush count", count, 0); chk("flush en", dutEn, 4'b0000);
    idle(); cycle();
    chk("postflush en", dutEn, 4'b0000);
    setA(1, 3, 77); cycle();
    idle(); cycle();
    chk("postflush en1", en1, 1'b1); chk("postflush val1", v1, 77);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 39) == 0);
      setA($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom},
           ($urandom_range(0, 3) == 0), {$urandom, $urandom});
      setB($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom},
           ($urandom_range(0, 3) == 0), {$urandom, $urandom});
      cycle();
    end
    idle();
    repeat (10) cycle();
    chk("final count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_writeback_queue.md
Name: fx_writeback_queue

Overview:
- Buffers fixed-point execution results and drains them in order onto the FX register file's four GPR write ports and its XER write port.
- Sits directly upstream of the FX register file.
- Accepts up to two results per cycle and issues up to four GPR writes per cycle.
- Never presents two writes to the same GPR, or more than one XER write, in a single cycle.

Parameters:
- regSize, 64, width of GPR and XER values.
- numGPRAddressBits, 6, GPR address width.
- queueDepth, 8, FIFO entries; power of two, minimum 4.
- fxWbInstance, 0, instance identifier used only in debug display text.

Ports:
- clock_i  in  1  single clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; discards all queued entries.
- resAValid_i  in  1  result A valid.
- resAAddr_i  in  numGPRAddressBits  result A target GPR.
- resAVal_i  in  regSize  result A value.
- resAXerEn_i  in  1  result A also updates XER.
- resAXerVal_i  in  regSize  result A XER value.
- resBValid_i, resBAddr_i, resBVal_i, resBXerEn_i, resBXerVal_i  in  same widths  result B; same meanings as result A.
- inReady_o  out  1  queue can accept two results this cycle.
- gprWrite1En_o..gprWrite4En_o  out  1 each  GPR write enables.
- gprWriteAddr1_o..gprWriteAddr4_o  out  numGPRAddressBits each  GPR write addresses.
- gprWrite1Val_o..gprWrite4Val_o  out  regSize each  GPR write values.
- XERWriteEn_o  out  1  XER write enable.
- XERVal_o  out  regSize  XER write value.
- count_o  out  log2(queueDepth)+1  current occupancy.

Behaviour:
- Reset (reset_i low, any time, including mid-drain):
  - count_o = 0; head and tail pointers = 0.
  - All write enables, addresses, values, XERWriteEn_o and XERVal_o = 0.
  - inReady_o = 1 once reset is released.
- inReady_o = (count_o <= queueDepth-2). It is combinational from registered count and does not credit entries dequeued in the same cycle.
- Enqueue at the rising edge:
  - Only when inReady_o = 1.
  - If both results are valid, A is written at tail and B at tail+1.
  - If only B is valid, B is written at tail.
  - Pointers wrap modulo queueDepth.
  - A valid result arriving while inReady_o = 0 is a producer protocol violation. It is dropped, and a $display warning is issued under DEBUG.
- Drain selection (combinational from head, evaluated every cycle):
  - Walk entries head, head+1, head+2, head+3 while they are occupied.
  - Stop before an entry whose address matches any already-selected entry.
  - Stop before a second XER-flagged entry.
  - Selection is strictly in order; no skipping.
  - Selecting 0 entries is legal.
- Drain outputs are registered:
  - Selected entry k drives port k+1 (lowest port = oldest entry) at the next edge.
  - Unused ports have enable 0; their address and value hold their previous contents.
  - XERWriteEn_o = 1 with XERVal_o taken from the selected XER-flagged entry.
  - Head advances by the number selected.
- Latency: a result enqueued at edge E appears on the write ports after edge E+1 when the queue is empty. The register file commits it at edge E+2.
- Ordering guarantee: writes to the same GPR reach the ports in enqueue order, in different cycles.
- Simultaneous enqueue and drain in one cycle:
  - count_next = count + enq - deq.
  - On an empty queue, an entry never drains in the same edge it is enqueued.
- Full: count_o = queueDepth is reachable only from count = queueDepth-1 plus a single enqueue. Not reachable under the two-slot ready rule, but the design must not overflow if it occurs.
- flush_i at an edge:
  - count and pointers go to 0.
  - All write enables go to 0 after that edge.
  - Enqueues in the same cycle are discarded.
  - Flush has priority over enqueue and drain.

Test Plan:
- Reset then idle: all enables 0, count_o = 0, inReady_o = 1. Pulse reset_i low mid-drain with 3 entries queued -> enables 0 immediately, count_o = 0.
- Enqueue A = (r0,10) and B = (r1,11), then one cycle later A = (r2,12), B = (r3,13) -> first cycle ports 1-2 = r0/10, r1/11; next cycle r2/12, r3/13; count_o returns to 0.
- Same-address hazard: enqueue r5 = 20, r5 = 21, r6 = 22 (third in the next cycle) -> cycle 1 drains only r5 = 20; cycle 2 drains r5 = 21 and r6 = 22. Register file read of r5 afterwards = 21.
- XER limit: two XER-flagged entries with XER values 0xA5FF00C3C300FFA5 then 0x1 -> first drain cycle XERWriteEn_o = 1 with 0xA5FF00C3C300FFA5, stopping before the second; the next cycle writes 0x1.
- Fill/backpressure: two results per cycle with drain constrained by all-same addresses, until count_o = 7 -> inReady_o = 0; it reasserts once count_o <= 6. Pointer wrap past entry 7 yields values in correct order.
- Flush with 5 entries queued and both inputs valid -> count_o = 0 next cycle, no write enables asserted afterwards, new entries accepted the following cycle.
